// File: rtl/voice_seg_display_top_if.sv
// Address/strobe bus shared by the program-space and data-space decoders,
// together with the registered chip selects and SRAM strobes they produce.
interface voice_seg_display_top_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic        Control_Module;
    logic        UART1;
    logic        CE0;
    logic        CE1;
    logic        OE0;
    logic        OE1;
    logic        WE0;
    logic        WE1;
    logic        CS0;
    logic        CS1;
    logic        WP;

    modport master (
        output address, read, write,
        input  Control_Module, UART1, CE0, CE1, OE0, OE1, WE0, WE1, CS0, CS1, WP
    );

    modport slave (
        input  address, read, write,
        output Control_Module, UART1, CE0, CE1, OE0, OE1, WE0, WE1, CS0, CS1, WP
    );
endinterface

// File: rtl/voice_seg_display_top.sv
// Voice-interactive 7-segment display top: sine generator, three LFSR noise
// sources, registered flash/SRAM/peripheral decoders and the voice-command FSM.
module voice_seg_display_top (
    input  logic                          clk,
    input  logic                          nRESET,
    voice_seg_display_top_if.slave        bus,
    input  logic [5:0]                    ID,
    output logic signed [7:0]             out,
    output logic [3:0]                    lfsr_4bit,
    output logic [7:0]                    lfsr_8bit,
    output logic [31:0]                   lfsr_32bit,
    output logic [13:0]                   Seven_Segment_Display
);

    localparam logic [3:0]  DIGIT_EMPTY = 4'hF;
    localparam logic [13:0] DISPLAY_BLANK = 14'h3FFF;

    typedef enum logic [1:0] {IDLE, START, RECORD, DONE} state_t;

    // Only the first quarter wave is stored; the other three are mirrored/negated.
    function automatic logic [6:0] quarter_sine(input logic [4:0] q);
        case (q)
            5'd0:    quarter_sine = 7'd0;
            5'd1:    quarter_sine = 7'd12;
            5'd2:    quarter_sine = 7'd25;
            5'd3:    quarter_sine = 7'd37;
            5'd4:    quarter_sine = 7'd49;
            5'd5:    quarter_sine = 7'd60;
            5'd6:    quarter_sine = 7'd71;
            5'd7:    quarter_sine = 7'd81;
            5'd8:    quarter_sine = 7'd90;
            5'd9:    quarter_sine = 7'd98;
            5'd10:   quarter_sine = 7'd106;
            5'd11:   quarter_sine = 7'd112;
            5'd12:   quarter_sine = 7'd117;
            5'd13:   quarter_sine = 7'd122;
            5'd14:   quarter_sine = 7'd125;
            5'd15:   quarter_sine = 7'd126;
            5'd16:   quarter_sine = 7'd127;
            default: quarter_sine = 7'd0;
        endcase
    endfunction

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
    endfunction

    logic [5:0] sine_idx;
    logic [4:0] sine_q;
    logic [6:0] sine_mag;

    always_comb begin
        sine_q   = sine_idx[4] ? (5'd16 - {1'b0, sine_idx[3:0]}) : {1'b0, sine_idx[3:0]};
        sine_mag = quarter_sine(sine_q);
        out      = sine_idx[5] ? -$signed({1'b0, sine_mag}) : $signed({1'b0, sine_mag});
    end

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            sine_idx   <= '0;
            lfsr_4bit  <= 4'h1;
            lfsr_8bit  <= 8'h01;
            lfsr_32bit <= 32'h1;
        end else begin
            sine_idx   <= sine_idx + 6'd1;
            lfsr_4bit  <= {lfsr_4bit[2:0], lfsr_4bit[3] ^ lfsr_4bit[2]};
            lfsr_8bit  <= {lfsr_8bit[6:0], lfsr_8bit[7] ^ lfsr_8bit[5] ^ lfsr_8bit[4] ^ lfsr_8bit[3]};
            lfsr_32bit <= {lfsr_32bit[30:0], lfsr_32bit[31] ^ lfsr_32bit[21] ^ lfsr_32bit[1] ^ lfsr_32bit[0]};
        end
    end

    logic hit_cs0, hit_cs1, hit_ce0, hit_ce1, hit_ctrl, hit_uart;

    always_comb begin
        hit_cs0  = bus.address <= 32'h07FF_FFFF;
        hit_cs1  = (bus.address >= 32'h0800_0000) && (bus.address <= 32'h0FFF_FFFF);
        hit_ce0  = (bus.address >= 32'h1000_0000) && (bus.address <= 32'h13FF_FFFF);
        hit_ce1  = (bus.address >= 32'h1400_0000) && (bus.address <= 32'h17FF_FFFF);
        hit_ctrl = (bus.address >= 32'h44E1_0000) && (bus.address <= 32'h44E1_1FFF);
        hit_uart = (bus.address >= 32'h4802_2000) && (bus.address <= 32'h4802_2FFF);
    end

    // Write has priority over read, so OE is suppressed whenever write is high.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            bus.CS0            <= 1'b0;
            bus.CS1            <= 1'b0;
            bus.WP             <= 1'b0;
            bus.CE0            <= 1'b0;
            bus.CE1            <= 1'b0;
            bus.OE0            <= 1'b0;
            bus.OE1            <= 1'b0;
            bus.WE0            <= 1'b0;
            bus.WE1            <= 1'b0;
            bus.Control_Module <= 1'b0;
            bus.UART1          <= 1'b0;
        end else begin
            bus.CS0            <= hit_cs0;
            bus.CS1            <= hit_cs1;
            bus.WP             <= hit_cs0 | hit_cs1;
            bus.CE0            <= hit_ce0;
            bus.CE1            <= hit_ce1;
            bus.OE0            <= hit_ce0 & bus.read & ~bus.write;
            bus.OE1            <= hit_ce1 & bus.read & ~bus.write;
            bus.WE0            <= hit_ce0 & bus.write;
            bus.WE1            <= hit_ce1 & bus.write;
            bus.Control_Module <= hit_ctrl;
            bus.UART1          <= hit_uart;
        end
    end

    state_t      state, next_state;
    logic [5:0]  id_r, id_prev;
    logic [3:0]  tens, ones, next_tens, next_ones, new_digit;
    logic        id_new, recordable;

    // Digit is taken from the low nibble minus the decade's low nibble, mod 16.
    always_comb begin
        id_new     = id_r != id_prev;
        recordable = (id_r >= 6'd10) && (id_r <= 6'd45);
        if (id_r >= 6'd40)      new_digit = id_r[3:0] - 4'd8;
        else if (id_r >= 6'd30) new_digit = id_r[3:0] - 4'd14;
        else if (id_r >= 6'd20) new_digit = id_r[3:0] - 4'd4;
        else                    new_digit = id_r[3:0] - 4'd10;

        next_state = state;
        next_tens  = tens;
        next_ones  = ones;
        if (id_new) begin
            if (id_r == 6'd0) begin
                next_state = IDLE;
            end else begin
                case (state)
                    IDLE: if (id_r == 6'd5) begin
                        next_state = START;
                        next_tens  = DIGIT_EMPTY;
                        next_ones  = DIGIT_EMPTY;
                    end
                    START, RECORD: if (recordable) begin
                        next_state = RECORD;
                        next_tens  = ones;
                        next_ones  = new_digit;
                    end else if (id_r == 6'd46) begin
                        next_state = DONE;
                    end
                    DONE: if (id_r == 6'd47) begin
                        next_state = START;
                        next_tens  = DIGIT_EMPTY;
                        next_ones  = DIGIT_EMPTY;
                    end
                endcase
            end
        end
    end

    // The display register is loaded from next-state values so it changes together with the state.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            id_r                  <= '0;
            id_prev               <= '0;
            state                 <= IDLE;
            tens                  <= DIGIT_EMPTY;
            ones                  <= DIGIT_EMPTY;
            Seven_Segment_Display <= DISPLAY_BLANK;
        end else begin
            id_r    <= ID;
            id_prev <= id_r;
            state   <= next_state;
            tens    <= next_tens;
            ones    <= next_ones;
            if ((next_state == RECORD) || (next_state == DONE))
                Seven_Segment_Display <= {seg(next_tens), seg(next_ones)};
            else
                Seven_Segment_Display <= DISPLAY_BLANK;
        end
    end

endmodule

// File: tb/tb_voice_seg_display_top.sv
// Directed self-checking bench for voice_seg_display_top: sine/LFSR sequences,
// decoder ranges and strobes, and the voice-command display FSM.
module tb_voice_seg_display_top;

    logic               clk;
    logic               nRESET;
    logic [5:0]         ID;
    logic signed [7:0]  out;
    logic [3:0]         lfsr_4bit;
    logic [7:0]         lfsr_8bit;
    logic [31:0]        lfsr_32bit;
    logic [13:0]        Seven_Segment_Display;

    int checkCount = 0;
    int errorCount = 0;

    voice_seg_display_top_if bus();

    voice_seg_display_top dut (
        .clk                   (clk),
        .nRESET                (nRESET),
        .bus                   (bus),
        .ID                    (ID),
        .out                   (out),
        .lfsr_4bit             (lfsr_4bit),
        .lfsr_8bit             (lfsr_8bit),
        .lfsr_32bit            (lfsr_32bit),
        .Seven_Segment_Display (Seven_Segment_Display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Selects packed as {CS0,CS1,WP,CE0,CE1,OE0,OE1,WE0,WE1,Control_Module,UART1}.
    function automatic logic [31:0] selects();
        return {21'd0, bus.CS0, bus.CS1, bus.WP, bus.CE0, bus.CE1, bus.OE0, bus.OE1,
                bus.WE0, bus.WE1, bus.Control_Module, bus.UART1};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic rd, input logic wr, input logic [5:0] id);
        bus.address = addr;
        bus.read    = rd;
        bus.write   = wr;
        ID          = id;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int sineTable [17] = '{0, 12, 25, 37, 49, 60, 71, 81, 90, 98, 106, 112, 117, 122, 125, 126, 127};
    logic [3:0] lfsr4Table [5] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3};

    logic [31:0] decAddr [19] = '{
        32'h0000_0BCD, 32'h0800_0CBA, 32'h2000_0DEF,
        32'h1000_08AD, 32'h1000_08AD, 32'h1000_08AD, 32'h1000_08AD,
        32'h1400_0F32, 32'h1400_0F32, 32'h1400_0F32,
        32'h44E1_0ABC, 32'h4802_2C58, 32'h44E1_28AD, 32'h4802_3BBB,
        32'h0FFF_FFFF, 32'h17FF_FFFF, 32'h1800_0000, 32'h44E1_1FFF, 32'h4802_2FFF};
    logic decRead  [19] = '{0,0,0, 0,1,0,1, 0,1,0, 1,0,0,0, 0,0,1,0,0};
    logic decWrite [19] = '{0,0,0, 0,0,1,1, 0,0,1, 0,0,0,0, 0,0,0,0,0};
    logic [31:0] decExpect [19] = '{
        32'h500, 32'h300, 32'h000,
        32'h080, 32'h0A0, 32'h088, 32'h088,
        32'h040, 32'h050, 32'h044,
        32'h002, 32'h001, 32'h000, 32'h000,
        32'h300, 32'h040, 32'h000, 32'h002, 32'h001};

    logic [5:0]  fsmId     [14] = '{5, 13, 13, 35, 44, 46, 13, 47, 30, 38, 46, 0, 5, 13};
    int          fsmHold   [14] = '{2, 1, 1, 2, 2, 2, 2, 2, 4, 2, 2, 2, 2, 2};
    logic [31:0] fsmExpect [14] = '{
        32'h3FFF, 32'h3FFF, 32'h3FB0, 32'h1812, 32'h0919, 32'h0919, 32'h0919,
        32'h3FFF, 32'h3FC0, 32'h2000, 32'h2000, 32'h3FFF, 32'h3FFF, 32'h3FB0};

    initial begin
        applyStimulus(32'h2000_0000, 1'b0, 1'b0, 6'd0);
        nRESET = 1'b1;
        #1 nRESET = 1'b0;
        #2;
        $display("[TB] reset asserted");
        checkOutput("rst_display", {18'd0, Seven_Segment_Display}, 32'h3FFF);
        checkOutput("rst_out", {24'd0, out}, 32'h0);
        checkOutput("rst_lfsr4", {28'd0, lfsr_4bit}, 32'h1);
        checkOutput("rst_lfsr8", {24'd0, lfsr_8bit}, 32'h01);
        checkOutput("rst_lfsr32", lfsr_32bit, 32'h1);
        checkOutput("rst_selects", selects(), 32'h0);

        step(1);
        nRESET = 1'b1;
        checkOutput("sine_k0", {24'd0, out}, 32'h0);
        checkOutput("lfsr4_0", {28'd0, lfsr_4bit}, 32'h1);
        for (int i = 1; i <= 16; i++) begin
            step(1);
            checkOutput("sine_ramp", {24'd0, out}, {24'd0, 8'(sineTable[i])});
            if (i <= 4) checkOutput("lfsr4_seq", {28'd0, lfsr_4bit}, {28'd0, lfsr4Table[i]});
            if (i == 1) begin
                checkOutput("lfsr8_first", {24'd0, lfsr_8bit}, 32'h02);
                checkOutput("lfsr32_first", lfsr_32bit, 32'h3);
            end
        end
        step(16);
        checkOutput("sine_k32", {24'd0, out}, 32'h0);
        step(16);
        checkOutput("sine_k48", {24'd0, out}, 32'h81);
        step(16);
        checkOutput("sine_wrap", {24'd0, out}, 32'h0);

        $display("[TB] decoder checks");
        for (int i = 0; i < 19; i++) begin
            applyStimulus(decAddr[i], decRead[i], decWrite[i], 6'd0);
            step(1);
            checkOutput("decode", selects(), decExpect[i]);
        end
        applyStimulus(32'h07FF_FFFF, 1'b0, 1'b0, 6'd0);
        #1 checkOutput("decode_latency", selects(), 32'h001);
        step(1);
        checkOutput("decode_cs0_top", selects(), 32'h500);

        $display("[TB] command FSM checks");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(32'h2000_0000, 1'b0, 1'b0, fsmId[i]);
            step(fsmHold[i]);
            checkOutput("display", {18'd0, Seven_Segment_Display}, fsmExpect[i]);
        end

        nRESET = 1'b0;
        #1 checkOutput("reset_mid_record", {18'd0, Seven_Segment_Display}, 32'h3FFF);
        step(2);
        nRESET = 1'b1;
        step(3);
        checkOutput("after_reset_idle", {18'd0, Seven_Segment_Display}, 32'h3FFF);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
